// File: rtl/line_buffer_pkg.sv
// Shared types, pipeline depth and bank-rotation helper for the vertical window line buffer.
package line_buffer_pkg;

  typedef enum logic {
    BORDER_ZERO      = 1'b0,
    BORDER_REPLICATE = 1'b1
  } border_mode_t;

  localparam int LATENCY = 3;

  // Bank holding the line completed 'age' lines ago, given the bank now being written.
  function automatic int bank_of_age(input int wr_bank, input int age, input int k);
    return (wr_bank + k + 1 - age) % (k + 1);
  endfunction

endpackage

// File: rtl/line_buffer_bank.sv
// One line bank: simple dual-port RAM, port A writes, port B reads read-first with a
// registered output (two-cycle read, equivalent to the high-performance BRAM template).
module line_buffer_bank #(
  parameter int DEPTH  = 1280,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_ram_q;
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_ram_q   <= r_mem[i_rd_addr];
    r_rd_data <= r_ram_q;
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/line_buffer_window.sv
// K-row vertical window generator: K+1 rotating line banks, fixed 3-cycle pipeline and
// top/bottom border substitution (zero fill or replicate nearest edge row).
module line_buffer_window
  import line_buffer_pkg::*;
#(
  parameter int HRES        = 1280,
  parameter int VRES        = 720,
  parameter int KERNEL_SIZE = 3,
  parameter int PIXEL_WIDTH = 16
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [10:0]                        hcount_in,
  input  logic [9:0]                         vcount_in,
  input  logic [PIXEL_WIDTH-1:0]             pixel_data_in,
  input  logic                               data_valid_in,
  input  logic                               border_mode_in,
  output logic [KERNEL_SIZE*PIXEL_WIDTH-1:0] line_buffer_out,
  output logic [10:0]                        hcount_out,
  output logic [9:0]                         vcount_out,
  output logic                               data_valid_out
);

  localparam int K      = KERNEL_SIZE;
  localparam int NB     = K + 1;
  localparam int BW     = $clog2(NB);
  localparam int HALF   = K / 2;
  localparam int PD     = LATENCY - 1;
  localparam int AW     = (HRES > 1) ? $clog2(HRES) : 1;
  localparam logic signed [10:0] C_OFF  = 11'(1 + HALF);
  localparam logic signed [10:0] C_VRES = 11'(VRES);

  if (KERNEL_SIZE < 3 || KERNEL_SIZE > 7 || (KERNEL_SIZE % 2) == 0) begin : g_bad_kernel
    $error("KERNEL_SIZE must be odd and within 3..7");
  end

  // Valid-only stream, no backpressure: every cycle with data_valid_in high is one pixel,
  // and it reappears as exactly one data_valid_out cycle LATENCY clocks later.
  logic [BW-1:0]   r_wr_bank;
  border_mode_t    r_mode_q;
  logic [10:0]     r_h_pipe    [PD];
  logic [9:0]      r_v_pipe    [PD];
  logic            r_vld_pipe  [PD];
  logic [BW-1:0]   r_bank_pipe [PD];
  logic [K*PIXEL_WIDTH-1:0] r_window;
  logic [10:0]     r_hcount_out;
  logic [9:0]      r_vcount_out;
  logic            r_valid_out;

  logic signed [10:0]       w_vc_s;
  logic [9:0]               w_vcount_ctr;
  logic [PIXEL_WIDTH-1:0]   w_rd_data [NB];
  logic [K*PIXEL_WIDTH-1:0] w_window;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_bank <= '0;
      r_mode_q  <= BORDER_ZERO;
    end else if (data_valid_in) begin
      if (hcount_in == 11'(HRES - 1))
        r_wr_bank <= (r_wr_bank == BW'(NB - 1)) ? '0 : r_wr_bank + 1'b1;
      if (hcount_in == '0 && vcount_in == '0)
        r_mode_q <= border_mode_t'(border_mode_in);
    end
  end

  // Centre row lags the incoming row by one completed line plus half a kernel, wrapping.
  assign w_vc_s       = $signed({1'b0, vcount_in}) - C_OFF;
  assign w_vcount_ctr = w_vc_s[10] ? 10'(w_vc_s + C_VRES) : w_vc_s[9:0];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    line_buffer_bank #(
      .DEPTH (HRES),
      .WIDTH (PIXEL_WIDTH),
      .ADDR_W(AW)
    ) u_bank (
      .i_clk    (clk_in),
      .i_wr_en  (data_valid_in && (r_wr_bank == BW'(b))),
      .i_wr_addr(hcount_in[AW-1:0]),
      .i_wr_data(pixel_data_in),
      .i_rd_addr(hcount_in[AW-1:0]),
      .o_rd_data(w_rd_data[b])
    );
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < PD; s++) begin
        r_h_pipe[s]    <= '0;
        r_v_pipe[s]    <= '0;
        r_vld_pipe[s]  <= 1'b0;
        r_bank_pipe[s] <= '0;
      end
    end else begin
      r_h_pipe[0]    <= hcount_in;
      r_v_pipe[0]    <= w_vcount_ctr;
      r_vld_pipe[0]  <= data_valid_in;
      r_bank_pipe[0] <= r_wr_bank;
      for (int s = 1; s < PD; s++) begin
        r_h_pipe[s]    <= r_h_pipe[s-1];
        r_v_pipe[s]    <= r_v_pipe[s-1];
        r_vld_pipe[s]  <= r_vld_pipe[s-1];
        r_bank_pipe[s] <= r_bank_pipe[s-1];
      end
    end
  end

  // Window slot i holds row centre-HALF+i, i.e. the line of age K-i; out-of-frame rows
  // either zero or borrow the slot that holds the nearest edge row.
  always_comb begin
    int   vc;
    int   row;
    int   src;
    logic zero;
    w_window = '0;
    vc       = int'(r_v_pipe[PD-1]);
    row      = 0;
    src      = 0;
    zero     = 1'b0;
    for (int i = 0; i < K; i++) begin
      row  = vc - HALF + i;
      src  = i;
      zero = 1'b0;
      if (row < 0) begin
        src  = HALF - vc;
        zero = (r_mode_q == BORDER_ZERO);
      end else if (row > VRES - 1) begin
        src  = VRES - 1 - vc + HALF;
        zero = (r_mode_q == BORDER_ZERO);
      end
      if (!zero)
        w_window[i*PIXEL_WIDTH +: PIXEL_WIDTH] =
          w_rd_data[BW'(bank_of_age(int'(r_bank_pipe[PD-1]), K - src, K))];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_window     <= '0;
      r_hcount_out <= '0;
      r_vcount_out <= '0;
      r_valid_out  <= 1'b0;
    end else begin
      r_hcount_out <= r_h_pipe[PD-1];
      r_vcount_out <= r_v_pipe[PD-1];
      r_valid_out  <= r_vld_pipe[PD-1];
      if (r_vld_pipe[PD-1]) r_window <= w_window;
    end
  end

  assign line_buffer_out = r_window;
  assign hcount_out      = r_hcount_out;
  assign vcount_out      = r_vcount_out;
  assign data_valid_out  = r_valid_out;

endmodule
